softmax_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the multi-pass softmax datapath: max, sub/exp/sum, ln, presub/logsub/exp.

---
 rtl/softmax_seq_ctrl_pkg.sv | 25 ++
 rtl/sm_delay_line.sv | 40 ++++
 rtl/softmax_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/softmax_seq_ctrl_pkg.sv
// rtl/softmax_seq_ctrl_pkg.sv - shared state encoding and sizing helpers for the softmax sequencer
package softmax_seq_ctrl_pkg;

    localparam int ADDRSIZE_DEF = 8;

    // Top-level sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAX  = 3'd1;
    localparam logic [2:0] ST_SUM  = 3'd2;
    localparam logic [2:0] ST_LOGW = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    // Sub-phases inside LOGW: drain sum pipe, drain adder tree, wait for ln result
    localparam logic [1:0] LW_SUM  = 2'd0;
    localparam logic [1:0] LW_TREE = 2'd1;
    localparam logic [1:0] LW_LN   = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sm_delay_line.sv
// rtl/sm_delay_line.sv - 1-bit strobe delay line with async clear and sync flush
module sm_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            // Single-stage register; flush discards the strobe in flight
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    sr <= '0;
                else if (flush)
                    sr <= '0;
                else
                    sr <= din;
            end
        end else begin : g_multi
            // Shift strobe toward the output one stage per cycle
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    sr <= '0;
                else if (flush)
                    sr <= '0;
                else
                    sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - multi-pass softmax address/strobe sequencer
module softmax_seq_ctrl
    import softmax_seq_ctrl_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int MEM_LAT  = 1,
    parameter int EXP_LAT  = 1,
    parameter int TREE_LAT = 3,
    parameter int LN_LAT   = 1,
    parameter int OUT_LAT  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDRSIZE-1:0] start_addr,
    input  logic [ADDRSIZE-1:0] end_addr,
    output logic                busy,
    output logic                done,
    output logic [ADDRSIZE-1:0] addr,
    output logic [ADDRSIZE-1:0] sub0_inp_addr,
    output logic [ADDRSIZE-1:0] sub1_inp_addr,
    output logic                max_en,
    output logic                sum_clr,
    output logic                sum_en,
    output logic                ln_en,
    output logic                outp_valid
);

    localparam int WCW = $clog2(max3(MEM_LAT, TREE_LAT, LN_LAT) + 1);

    logic [2:0]          state;
    logic [1:0]          lw_phase;
    logic [WCW-1:0]      wcnt;
    logic [ADDRSIZE-1:0] first_addr;
    logic [ADDRSIZE-1:0] last_addr;

    logic rd_max;
    logic rd_sub;
    logic rd_out;
    logic sub_first;
    logic sub_last;
    logic out_last_rd;
    logic sum_last;
    logic out_last;

    // Read strobes: one per issued address; SUM holds off while wcnt drains the max pipe
    assign rd_max      = (state == ST_MAX);
    assign rd_sub      = (state == ST_SUM) && (wcnt == '0);
    assign rd_out      = (state == ST_OUT);
    assign sub_first   = rd_sub && (sub0_inp_addr == first_addr);
    assign sub_last    = rd_sub && (sub0_inp_addr == last_addr);
    assign out_last_rd = rd_out && (sub1_inp_addr == last_addr);
    assign ln_en       = (state == ST_LOGW) && (lw_phase == LW_TREE) && (wcnt == '0);

    // Sequencer FSM, address counters and busy/done handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            lw_phase      <= LW_SUM;
            wcnt          <= '0;
            first_addr    <= '0;
            last_addr     <= '0;
            addr          <= '0;
            sub0_inp_addr <= '0;
            sub1_inp_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            state         <= ST_IDLE;
            lw_phase      <= LW_SUM;
            wcnt          <= '0;
            addr          <= '0;
            sub0_inp_addr <= '0;
            sub1_inp_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_addr < end_addr) begin
                            first_addr <= start_addr;
                            last_addr  <= end_addr - ADDRSIZE'(1);
                            addr       <= start_addr;
                            busy       <= 1'b1;
                            state      <= ST_MAX;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_MAX: begin
                    if (addr == last_addr) begin
                        state         <= ST_SUM;
                        addr          <= '0;
                        sub0_inp_addr <= first_addr;
                        wcnt          <= WCW'(MEM_LAT - 1);
                    end else begin
                        addr <= addr + ADDRSIZE'(1);
                    end
                end
                ST_SUM: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - WCW'(1);
                    end else if (sub0_inp_addr == last_addr) begin
                        state         <= ST_LOGW;
                        sub0_inp_addr <= '0;
                        lw_phase      <= LW_SUM;
                    end else begin
                        sub0_inp_addr <= sub0_inp_addr + ADDRSIZE'(1);
                    end
                end
                ST_LOGW: begin
                    case (lw_phase)
                        LW_SUM: begin
                            if (sum_last) begin
                                wcnt     <= WCW'(TREE_LAT - 1);
                                lw_phase <= LW_TREE;
                            end
                        end
                        LW_TREE: begin
                            if (wcnt != '0) begin
                                wcnt <= wcnt - WCW'(1);
                            end else if (LN_LAT == 1) begin
                                state         <= ST_OUT;
                                sub1_inp_addr <= first_addr;
                            end else begin
                                wcnt     <= WCW'((LN_LAT > 1) ? LN_LAT - 2 : 0);
                                lw_phase <= LW_LN;
                            end
                        end
                        default: begin
                            if (wcnt != '0) begin
                                wcnt <= wcnt - WCW'(1);
                            end else begin
                                state         <= ST_OUT;
                                sub1_inp_addr <= first_addr;
                            end
                        end
                    endcase
                end
                ST_OUT: begin
                    if (sub1_inp_addr == last_addr) begin
                        state         <= ST_FIN;
                        sub1_inp_addr <= '0;
                    end else begin
                        sub1_inp_addr <= sub1_inp_addr + ADDRSIZE'(1);
                    end
                end
                ST_FIN: begin
                    if (out_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sm_delay_line #(.DEPTH(MEM_LAT)) u_dl_max (
        .clk(clk), .reset(reset), .flush(abort), .din(rd_max), .dout(max_en)
    );

    sm_delay_line #(.DEPTH(MEM_LAT + EXP_LAT)) u_dl_sum (
        .clk(clk), .reset(reset), .flush(abort), .din(rd_sub), .dout(sum_en)
    );

    sm_delay_line #(.DEPTH(MEM_LAT + EXP_LAT)) u_dl_sum_clr (
        .clk(clk), .reset(reset), .flush(abort), .din(sub_first), .dout(sum_clr)
    );

    sm_delay_line #(.DEPTH(MEM_LAT + EXP_LAT)) u_dl_sum_last (
        .clk(clk), .reset(reset), .flush(abort), .din(sub_last), .dout(sum_last)
    );

    sm_delay_line #(.DEPTH(MEM_LAT + OUT_LAT)) u_dl_out (
        .clk(clk), .reset(reset), .flush(abort), .din(rd_out), .dout(outp_valid)
    );

    sm_delay_line #(.DEPTH(MEM_LAT + OUT_LAT)) u_dl_out_last (
        .clk(clk), .reset(reset), .flush(abort), .din(out_last_rd), .dout(out_last)
    );

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb/tb_softmax_seq_ctrl.sv - self-checking bench for softmax_seq_ctrl
module tb_softmax_seq_ctrl;

    localparam int AW = 8;
    localparam int MA = 1, EA = 1, TA = 3, LA = 1, OA = 2;
    localparam int MB = 3, EB = 4, TB = 5, LB = 1, OB = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic          start_a, abort_a, start_b, abort_b;
    logic [AW-1:0] sa_a, ea_a, sa_b, ea_b;
    logic          busy_a, done_a, max_en_a, sum_clr_a, sum_en_a, ln_en_a, outp_valid_a;
    logic          busy_b, done_b, max_en_b, sum_clr_b, sum_en_b, ln_en_b, outp_valid_b;
    logic [AW-1:0] addr_a, sub0_a, sub1_a, addr_b, sub0_b, sub1_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    softmax_seq_ctrl #(
        .ADDRSIZE(AW), .MEM_LAT(MA), .EXP_LAT(EA), .TREE_LAT(TA), .LN_LAT(LA), .OUT_LAT(OA)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .start_addr(sa_a), .end_addr(ea_a), .busy(busy_a), .done(done_a),
        .addr(addr_a), .sub0_inp_addr(sub0_a), .sub1_inp_addr(sub1_a),
        .max_en(max_en_a), .sum_clr(sum_clr_a), .sum_en(sum_en_a),
        .ln_en(ln_en_a), .outp_valid(outp_valid_a)
    );

    softmax_seq_ctrl #(
        .ADDRSIZE(AW), .MEM_LAT(MB), .EXP_LAT(EB), .TREE_LAT(TB), .LN_LAT(LB), .OUT_LAT(OB)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .start_addr(sa_b), .end_addr(ea_b), .busy(busy_b), .done(done_b),
        .addr(addr_b), .sub0_inp_addr(sub0_b), .sub1_inp_addr(sub1_b),
        .max_en(max_en_b), .sum_clr(sum_clr_b), .sum_en(sum_en_b),
        .ln_en(ln_en_b), .outp_valid(outp_valid_b)
    );

    function automatic logic [30:0] get_obs(input bit b);
        if (b)
            return {busy_b, done_b, max_en_b, sum_clr_b, sum_en_b, ln_en_b, outp_valid_b,
                    addr_b, sub0_b, sub1_b};
        return {busy_a, done_a, max_en_a, sum_clr_a, sum_en_a, ln_en_a, outp_valid_a,
                addr_a, sub0_a, sub1_a};
    endfunction

    // Expected outputs k cycles after the start cycle, from the pass schedule:
    // MAX sweep, SUM sweep after the max pipe drains, ln after the tree drains,
    // OUT sweep after ln latency, done one cycle after the last outp_valid.
    function automatic logic [30:0] exp_obs(input int m, input int e, input int t, input int l,
                                            input int o, input int sa, input int n, input int k);
        int d, s0, o0;
        logic bz, dn, mx, sc, se, ln, ov;
        logic [7:0] a0, a1, a2;
        {bz, dn, mx, sc, se, ln, ov} = '0;
        a0 = '0; a1 = '0; a2 = '0;
        if (n == 0) begin
            dn = (k == 1);
        end else begin
            d  = 3*n + 3*m + e + t + l + o - 1;
            s0 = n + m;
            o0 = 2*n + 2*m + e + t + l - 1;
            bz = (k >= 1) && (k < d);
            dn = (k == d);
            if (k >= 1 && k <= n) a0 = 8'(sa + k - 1);
            mx = (k >= 1 + m) && (k <= n + m);
            if (k > n && k < s0) a1 = 8'(sa);
            else if (k >= s0 && k < s0 + n) a1 = 8'(sa + k - s0);
            se = (k >= s0 + m + e) && (k < s0 + n + m + e);
            sc = (k == s0 + m + e);
            ln = (k == s0 + n - 1 + m + e + t);
            if (k >= o0 && k < o0 + n) a2 = 8'(sa + k - o0);
            ov = (k >= o0 + m + o) && (k < o0 + n + m + o);
        end
        return {bz, dn, mx, sc, se, ln, ov, a0, a1, a2};
    endfunction

    task automatic drive(input bit b, input logic st, input logic ab, input int sa, input int ea);
        if (b) begin
            start_b = st; abort_b = ab; sa_b = 8'(sa); ea_b = 8'(ea);
        end else begin
            start_a = st; abort_a = ab; sa_a = 8'(sa); ea_a = 8'(ea);
        end
    endtask

    // Start one vector and compare every output each cycle until a few cycles past done.
    // abort_at/restart_at/reset_at (cycle index, -1 = unused) inject events mid-run.
    task automatic run_vec(input bit b, input int sa, input int ea, input int abort_at,
                           input int restart_at, input int reset_at, input string name);
        int m, e, t, l, o, n, d, len;
        logic [30:0] obs, exp_v;
        if (b) begin m = MB; e = EB; t = TB; l = LB; o = OB; end
        else   begin m = MA; e = EA; t = TA; l = LA; o = OA; end
        n   = (ea > sa) ? ea - sa : 0;
        d   = (n == 0) ? 1 : 3*n + 3*m + e + t + l + o - 1;
        len = d + 3;
        @(negedge clk);
        drive(b, 1'b1, abort_at == 0, sa, ea);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            obs   = get_obs(b);
            exp_v = (abort_at >= 0 && k > abort_at) ? '0 : exp_obs(m, e, t, l, o, sa, n, k);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h", name, k, obs, exp_v);
            end
            if (k == reset_at) begin
                drive(b, 1'b0, 1'b0, 0, 0);
                reset = 1'b0;
                #1;
                checks++;
                if (get_obs(b) !== 31'd0) begin
                    errors++;
                    $display("FAIL %s async_clear: got %h required 0", name, get_obs(b));
                end
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            drive(b, k == restart_at, k == abort_at,
                  (k == restart_at) ? 20 : sa, (k == restart_at) ? 30 : ea);
        end
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (get_obs(1'b0) !== 31'd0) begin
            errors++;
            $display("FAIL reset_a: got %h required 0", get_obs(1'b0));
        end
        checks++;
        if (get_obs(1'b1) !== 31'd0) begin
            errors++;
            $display("FAIL reset_b: got %h required 0", get_obs(1'b1));
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_vec(1'b0, 0, 4, -1, -1, -1, "basic_0_4");
    endtask

    task automatic test_empty;
        run_vec(1'b0, 5, 5, -1, -1, -1, "empty_5_5");
        run_vec(1'b0, 9, 3, -1, -1, -1, "inverted_9_3");
    endtask

    task automatic test_param_latency;
        run_vec(1'b1, 0, 8, -1, -1, -1, "lat_b_0_8");
    endtask

    task automatic test_abort;
        run_vec(1'b0, 0, 4, 7, -1, -1, "abort_sum3");
        run_vec(1'b0, 0, 2, -1, -1, -1, "after_abort");
        run_vec(1'b0, 3, 6, 0, -1, -1, "start_abort_same");
    endtask

    task automatic test_start_while_busy;
        run_vec(1'b0, 0, 4, -1, 3, -1, "start_busy");
    endtask

    task automatic test_async_reset;
        run_vec(1'b0, 0, 4, -1, -1, 15, "reset_out");
        run_vec(1'b0, 10, 12, -1, -1, -1, "post_reset");
    endtask

    task automatic test_boundary;
        run_vec(1'b0, 250, 255, -1, -1, -1, "top_end_a");
        run_vec(1'b1, 254, 255, -1, -1, -1, "top_end_b");
    endtask

    task automatic test_back_to_back;
        int n, sa;
        for (int i = 0; i < 6; i++) begin
            n  = $urandom_range(1, 6);
            sa = $urandom_range(0, 255 - n);
            run_vec(1'b0, sa, sa + n, -1, -1, -1, "rand_a");
        end
        for (int i = 0; i < 2; i++) begin
            n  = $urandom_range(1, 5);
            sa = $urandom_range(0, 255 - n);
            run_vec(1'b1, sa, sa + n, -1, -1, -1, "rand_b");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_empty;
        test_param_latency;
        test_abort;
        test_start_while_busy;
        test_async_reset;
        test_boundary;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
